// File: rtl/jailbreak_dip_loader.sv
// jailbreak_dip_loader: stages DIP-switch writes from the APF bridge and
// applies them atomically to the Jailbreak core while holding it in reset.
// Optional macro JAILBREAK_DIP_READBACK_EN adds a registered bridge readback
// of the staged word, status and active word; without it bridge_rd_data is 0.
//
// Bridge handshake: bridge_wr / bridge_rd are single-cycle strobes qualified
// by an exact bridge_addr match; there is no back-pressure, every strobe is
// accepted in the cycle it is seen, and read data appears one cycle later.
module jailbreak_dip_loader #(
    parameter logic [31:0] DIP_ADDR          = 32'hF000_0000,
    parameter int          RESET_HOLD_CYCLES = 16,
    parameter logic [17:0] DIP_DEFAULT       = 18'h01600
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        bridge_wr,
    input  logic        bridge_rd,
    input  logic [31:0] bridge_addr,
    input  logic [31:0] bridge_wr_data,
    output logic [31:0] bridge_rd_data,
    output logic [17:0] dip,
    output logic        game_reset_n,
    output logic        apply_pending,
    output logic        apply_done
);

    localparam int              CW        = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(RESET_HOLD_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(1);

    // S_HOLD keeps the core in reset; S_RUN lets it execute.
    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [17:0]   staged_q, staged_d;
    logic [17:0]   dip_q, dip_d;
    logic          pending_q, pending_d;
    logic          done_q, done_d;

    logic wr_stage;
    logic wr_apply;

    // Only exact byte-address matches decode; everything else is dropped.
    assign wr_stage = bridge_wr && (bridge_addr == DIP_ADDR);
    assign wr_apply = bridge_wr && (bridge_addr == (DIP_ADDR + 32'd4));

    // Bits above the DIP word and the unused bit 14 never reach state.
    logic unused_wr_bits;
    assign unused_wr_bits = ^{bridge_wr_data[31:18], bridge_wr_data[14]};

    // State registers; reset boots into a full hold with the default DIP word.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_HOLD;
            count_q   <= HOLD_LOAD;
            staged_q  <= DIP_DEFAULT;
            dip_q     <= DIP_DEFAULT;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            staged_q  <= staged_d;
            dip_q     <= dip_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: staging, apply/queue handling and the hold countdown.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        staged_d  = staged_q;
        dip_d     = dip_q;
        pending_d = pending_q;
        done_d    = 1'b0;

        if (wr_stage) begin
            staged_d = {bridge_wr_data[17:15], 1'b0, bridge_wr_data[13:0]};
        end

        case (state_q)
            S_RUN: begin
                if (wr_apply) begin
                    dip_d   = staged_q;
                    count_d = HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (wr_apply) begin
                    pending_d = 1'b1;
                end
                if (count_q == CNT_LAST) begin
                    // Last hold cycle: either chain the queued apply into a
                    // fresh hold, or release the core.
                    if (pending_q || wr_apply) begin
                        dip_d     = staged_q;
                        count_d   = HOLD_LOAD;
                        pending_d = 1'b0;
                    end else begin
                        count_d = '0;
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - CNT_LAST;
                end
            end
            default: begin
                state_d = S_HOLD;
                count_d = HOLD_LOAD;
            end
        endcase
    end

    assign dip           = dip_q;
    assign game_reset_n  = (state_q == S_RUN);
    assign apply_pending = pending_q;
    assign apply_done    = done_q;

`ifdef JAILBREAK_DIP_READBACK_EN
    logic [31:0] rd_data_q, rd_data_d;

    // Read mux; the result is captured only on a read strobe.
    always_comb begin
        rd_data_d = rd_data_q;
        if (bridge_rd) begin
            if (bridge_addr == DIP_ADDR) begin
                rd_data_d = {14'b0, staged_q};
            end else if (bridge_addr == (DIP_ADDR + 32'd4)) begin
                rd_data_d = {30'b0, pending_q, ~game_reset_n};
            end else if (bridge_addr == (DIP_ADDR + 32'd8)) begin
                rd_data_d = {14'b0, dip_q};
            end else begin
                rd_data_d = 32'h0;
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= 32'h0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bridge_rd_data = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd      = bridge_rd;
    assign bridge_rd_data = 32'h0;
`endif

endmodule
